img_scaler_pipe: RTL and testbench
==================================

// Module: img_scaler_pipe
// PURPOSE
//  Registered, parametrised frame-buffer-to-VGA pixel path. Sits between the VGA timing
//  generator (DE, x, y) and a synchronous RGB565 frame-buffer ROM/RAM.
//  Generates read addresses with counters (no multiplier). Supports 1x/2x/4x integer upscale,
//  selectable at run time. Aligns DE to the memory read latency and outputs RGB444.
//  Pixels outside the scaled image are black.
// PARAMETERS
//  SRC_W   320                    source image width in pixels
//  SRC_H   240                    source image height in pixels
//  RD_LAT  1                      frame-buffer read latency in clk cycles (1..4)
//  ADDR_W  $clog2(SRC_W*SRC_H)    address width (derived, do not override)
// PORTS
//  clk        in   1       pixel clock
//  reset      in   1       asynchronous, active-high reset
//  DE         in   1       display-enable from VGA timing
//  x          in   10      active pixel column (valid while DE)
//  y          in   10      active pixel row (valid while DE)
//  scale_sel  in   2       0=1x, 1=2x, 2=4x, 3=reserved (treated as 2x)
//  sw_rgb     in   3       channel enables {R,G,B}; used only with IMG_CHANNEL_MASK_EN
//  imgData    in   16      RGB565 read data, valid RD_LAT cycles after addr/rd_en
//  addr       out  ADDR_W  frame-buffer read address (registered)
//  rd_en      out  1       read strobe (registered)
//  de_out     out  1       DE delayed to align with colour outputs
//  r_port     out  4       red
//  g_port     out  4       green
//  b_port     out  4       blue
// BEHAVIOUR
//  - Reset values: addr=0, rd_en=0, de_out=0, r/g/b_port=0.
//    Internal counters are 0. The latched scale is 2x.
//  - Scale latch: scale_sel is sampled only on the cycle with DE=1, x=0, y=0.
//    Mid-frame changes take effect at the next frame. S = shift of 0/1/2.
//  - Column counter: cleared on the DE rising edge, so the pixel with x=0 maps to col 0.
//    A sub-counter counts 0..(2^S-1); col increments when it wraps.
//  - Row base: on the DE rising edge with y=0, row_base=0 and row=0.
//    On the DE falling edge, if y[S-1:0] is all ones (always true when S=0),
//    then row+=1 and row_base+=SRC_W.
//  - Read: addr = row_base + col and rd_en = 1, registered one edge after input sampling,
//    when DE=1, col<SRC_W and row<SRC_H.
//    Otherwise rd_en=0 and addr holds its last value.
//  - Latency: L = 1+RD_LAT edges from a (DE, x, y) input to its de_out/r/g/b.
//    This is fixed for all scales; de_out = DE delayed by L.
//  - Colour: {r,g,b} = {imgData[15:12], imgData[10:7], imgData[4:1]}, registered when the
//    delayed in-image flag is 1. Otherwise 12'h000.
//  - Outputs are forced to 0 whenever de_out=0.
//  - If DE drops mid-line, the line is treated as ended (falling-edge rule above).
//  - reset mid-frame clears everything. The first frame after release starts at the next
//    x=0, y=0. Before that, rd_en=0 and the outputs are black.
//  - No wrap: col and row saturate at SRC_W and SRC_H respectively, so the address never
//    exceeds SRC_W*SRC_H-1.
// CONFIGURATION
//  IMG_CHANNEL_MASK_EN
//    defined:   each colour channel is forced to 0 when its sw_rgb bit is 0
//               (sw_rgb[2]=R, [1]=G, [0]=B). sw_rgb is sampled in the output register
//               stage, so it needs no latency alignment.
//    undefined: sw_rgb is ignored and all channels pass through. The port remains present.
// STRUCTURE
//  - img_scaler_pkg:
//      scale_e enum (SCALE_1X, SCALE_2X, SCALE_4X)
//      rgb444_t packed struct
//      function rgb565_to_444()
//      localparam DISP_W=640, DISP_H=480
//  - Sub-module img_delay_line #(WIDTH, DEPTH): reset-cleared shift register that carries
//    {DE, in_img} through the L-stage alignment.
// TESTING
//  1. 2x, RD_LAT=1, full frame. Pixel (x=3, y=5) -> addr=2*320+1=641, with rd_en one edge
//     later. Its colour and de_out appear 2 edges after input.
//  2. 1x. Pixel (x=319, y=0) -> addr=319. Pixel (x=320, y=0) -> rd_en=0, black output.
//     Pixel (x=0, y=240) -> rd_en=0.
//  3. 4x. Pixel (x=639, y=479) -> addr=119*320+159=38239. Pixels x=4..7 on row 0 all give
//     addr=1.
//  4. scale_sel changed 2x->1x at y=100 -> frame stays 2x. The next frame at (0,0) gives
//     1x addressing.
//  5. imgData=16'hF81F with IMG_CHANNEL_MASK_EN and sw_rgb=3'b101 -> r=F, g=0, b=F.
//     Without the macro -> r=F, g=0, b=F regardless of sw_rgb.
//  6. reset asserted at x=200, y=150 -> all outputs 0 immediately (async).
//     After release, rd_en stays 0 until the next (0,0), then is correct. Repeat with
//     RD_LAT=3 to check that L=4.

Source files
------------

// File: rtl/img_scaler_pkg.sv
// Shared types and helpers for the frame-buffer-to-VGA scaler pixel path.
// Channel masking in the top is enabled by the IMG_CHANNEL_MASK_EN macro.
package img_scaler_pkg;

    localparam int DISP_W = 640;
    localparam int DISP_H = 480;

    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2
    } scale_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic rgb444_t rgb565_to_444(input logic [15:0] px);
        rgb444_t c;
        c.r = px[15:12];
        c.g = px[10:7];
        c.b = px[4:1];
        return c;
    endfunction

    // The reserved encoding falls back to 2x.
    function automatic scale_e decode_scale(input logic [1:0] sel);
        scale_e s;
        case (sel)
            2'd0:    s = SCALE_1X;
            2'd2:    s = SCALE_4X;
            default: s = SCALE_2X;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/img_scaler_pipe_delay.sv
// Reset-cleared shift register used to align control flags with frame-buffer read data.
module img_delay_line
    import img_scaler_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/img_scaler_pipe.sv
// Frame-buffer-to-VGA pixel path with counter-based 1x/2x/4x upscale and RGB565->RGB444.
// Define IMG_CHANNEL_MASK_EN to gate each colour channel with its sw_rgb bit.
module img_scaler_pipe
    import img_scaler_pkg::*;
#(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = $clog2(SRC_W * SRC_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              DE,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [1:0]        scale_sel,
    input  logic [2:0]        sw_rgb,
    input  logic [15:0]       imgData,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    output logic              de_out,
    output logic [3:0]        r_port,
    output logic [3:0]        g_port,
    output logic [3:0]        b_port
);

    localparam int COL_W = $clog2(SRC_W + 1);
    localparam int ROW_W = $clog2(SRC_H + 1);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(SRC_W);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(SRC_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    scale_e            scale_q, scale_cur;
    logic              frame_q, frame_d, frame_start;
    logic              de_q, rising, falling, line_done;
    logic [1:0]        y_lsb_q;
    logic [1:0]        sub_q, sub_d, sub_cur, sub_max;
    logic [COL_W-1:0]  col_q, col_d, col_cur;
    logic [ROW_W-1:0]  row_q, row_d, row_cur;
    logic [ADDR_W-1:0] base_q, base_d, base_cur;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, in_img;
    logic [1:0]        dly;
    logic              de_out_q;
    rgb444_t           pix, rgb_q, rgb_d;

    // A new frame may switch scale on its first pixel, so the current pixel uses the fresh value.
    always_comb begin
        frame_start = DE && (x == '0) && (y == '0);
        scale_cur   = frame_start ? decode_scale(scale_sel) : scale_q;
        rising      = DE && !de_q;
        falling     = !DE && de_q;
        col_cur     = rising ? '0 : col_q;
        sub_cur     = rising ? '0 : sub_q;
        row_cur     = (rising && (y == '0)) ? '0 : row_q;
        base_cur    = (rising && (y == '0)) ? '0 : base_q;

        case (scale_cur)
            SCALE_1X: sub_max = 2'd0;
            SCALE_2X: sub_max = 2'd1;
            default:  sub_max = 2'd3;
        endcase

        case (scale_q)
            SCALE_1X: line_done = 1'b1;
            SCALE_2X: line_done = y_lsb_q[0];
            default:  line_done = &y_lsb_q;
        endcase

        sub_d  = sub_cur;
        col_d  = col_cur;
        row_d  = row_cur;
        base_d = base_cur;

        if (DE) begin
            if (sub_cur == sub_max) begin
                sub_d = '0;
                if (col_cur < COL_MAX) col_d = col_cur + COL_W'(1);
            end else begin
                sub_d = sub_cur + 2'd1;
            end
        end

        // Row base stops one row early so it never exceeds the last valid line start.
        if (falling && line_done) begin
            if (row_q < ROW_MAX)                 row_d  = row_q + ROW_W'(1);
            if (row_q < ROW_MAX - ROW_W'(1))     base_d = base_q + ROW_STEP;
        end

        frame_d = frame_q || frame_start;
        in_img  = frame_d && DE && (col_cur < COL_MAX) && (row_cur < ROW_MAX);
        addr_d  = in_img ? (base_cur + ADDR_W'(col_cur)) : addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scale_q <= SCALE_2X;
            frame_q <= 1'b0;
            de_q    <= 1'b0;
            y_lsb_q <= '0;
            sub_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
        end else begin
            if (frame_start) scale_q <= scale_cur;
            if (DE)          y_lsb_q <= y[1:0];
            frame_q <= frame_d;
            de_q    <= DE;
            sub_q   <= sub_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            rd_en_q <= in_img;
        end
    end

    img_delay_line #(
        .WIDTH (2),
        .DEPTH (RD_LAT)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   ({DE, in_img}),
        .dout  (dly)
    );

`ifdef IMG_CHANNEL_MASK_EN
    always_comb begin
        pix = rgb565_to_444(imgData);
        if (!sw_rgb[2]) pix.r = '0;
        if (!sw_rgb[1]) pix.g = '0;
        if (!sw_rgb[0]) pix.b = '0;
        rgb_d = (dly[1] && dly[0]) ? pix : '0;
    end
`else
    logic sw_rgb_unused;
    assign sw_rgb_unused = ^sw_rgb;

    always_comb begin
        pix   = rgb565_to_444(imgData);
        rgb_d = (dly[1] && dly[0]) ? pix : '0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_out_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            de_out_q <= dly[1];
            rgb_q    <= rgb_d;
        end
    end

    assign addr   = addr_q;
    assign rd_en  = rd_en_q;
    assign de_out = de_out_q;
    assign r_port = rgb_q.r;
    assign g_port = rgb_q.g;
    assign b_port = rgb_q.b;

endmodule

// File: tb/tb_img_scaler_pipe.sv
// Self-checking bench for img_scaler_pipe: RD_LAT=1 and RD_LAT=3 instances share one stimulus.
// Expected values come from a raster-level model (addr = (y>>S)*SRC_W + (x>>S)) plus literals.
module tb_img_scaler_pipe;
    import img_scaler_pkg::*;

    localparam int SRC_W  = 320;
    localparam int SRC_H  = 240;
    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              DE = 1'b0;
    logic [9:0]        x = '0;
    logic [9:0]        y = '0;
    logic [1:0]        scale_sel = 2'd1;
    logic [2:0]        sw_rgb = 3'b101;

    logic [ADDR_W-1:0] addrA, addrB;
    logic              rdA, rdB, deA, deB;
    logic [3:0]        rA, gA, bA, rB, gB, bB;
    logic [15:0]       imgA, imgB;
    logic [15:0]       memDlyB [0:1];

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    img_scaler_pipe #(.SRC_W(SRC_W), .SRC_H(SRC_H), .RD_LAT(1)) dutA (
        .clk(clk), .reset(reset), .DE(DE), .x(x), .y(y), .scale_sel(scale_sel),
        .sw_rgb(sw_rgb), .imgData(imgA), .addr(addrA), .rd_en(rdA), .de_out(deA),
        .r_port(rA), .g_port(gA), .b_port(bA)
    );

    img_scaler_pipe #(.SRC_W(SRC_W), .SRC_H(SRC_H), .RD_LAT(3)) dutB (
        .clk(clk), .reset(reset), .DE(DE), .x(x), .y(y), .scale_sel(scale_sel),
        .sw_rgb(sw_rgb), .imgData(imgB), .addr(addrB), .rd_en(rdB), .de_out(deB),
        .r_port(rB), .g_port(gB), .b_port(bB)
    );

    // Frame-buffer contents: a hash, with one known magenta pixel at address 641.
    function automatic logic [15:0] memWord(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = {15'd0, a} * 32'h9E3779B1;
        if (a == 17'd641) return 16'hF81F;
        return t[23:8];
    endfunction

    // Memory with RD_LAT=1 is sampled the edge after addr; RD_LAT=3 adds two register stages.
    assign imgA = memWord(addrA);
    always @(posedge clk) begin
        memDlyB[1] <= memDlyB[0];
        memDlyB[0] <= memWord(addrB);
    end
    assign imgB = memDlyB[1];

    function automatic logic [11:0] applyMask(input logic [11:0] c, input logic [2:0] m);
        logic [11:0] res;
        res = c;
`ifdef IMG_CHANNEL_MASK_EN
        if (!m[2]) res[11:8] = 4'h0;
        if (!m[1]) res[7:4]  = 4'h0;
        if (!m[0]) res[3:0]  = 4'h0;
`else
        if (m == 3'b000) res = c;
`endif
        return res;
    endfunction

    typedef struct packed {
        logic        de;
        logic        img;
        logic [11:0] rgb;
    } expT;

    int              scaleLat;
    bit              frameStarted;
    bit              expRd;
    logic [ADDR_W-1:0] expAddr;
    expT             pipe [0:4];
    logic [2:0]      swAtEdge;

    // Behavioural model: scaled raster coordinates straight from x/y.
    always @(posedge clk or posedge reset) begin : modelProc
        int   c;
        int   r;
        bit   inImg;
        logic [15:0] w;
        if (reset) begin
            scaleLat     = 1;
            frameStarted = 1'b0;
            expRd        = 1'b0;
            expAddr      = '0;
            swAtEdge     = 3'b000;
            for (int i = 0; i < 5; i++) pipe[i] = '0;
        end else begin
            if (DE && x == 10'd0 && y == 10'd0) begin
                scaleLat     = (scale_sel == 2'd0) ? 0 : (scale_sel == 2'd2) ? 2 : 1;
                frameStarted = 1'b1;
            end
            c     = int'(x) >> scaleLat;
            r     = int'(y) >> scaleLat;
            inImg = frameStarted && DE && (c < SRC_W) && (r < SRC_H);
            expRd = inImg;
            if (inImg) expAddr = ADDR_W'(r * SRC_W + c);
            for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
            w = memWord(expAddr);
            pipe[0].de  = DE;
            pipe[0].img = inImg;
            pipe[0].rgb = inImg ? {w[15:12], w[10:7], w[4:1]} : 12'h000;
            swAtEdge = sw_rgb;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rdA", 32'(rdA), 32'(expRd));
            checkOutput("addrA", 32'(addrA), 32'(expAddr));
            checkOutput("deA", 32'(deA), 32'(pipe[1].de));
            checkOutput("rgbA", 32'({rA, gA, bA}), 32'(applyMask(pipe[1].rgb, swAtEdge)));
            checkOutput("rdB", 32'(rdB), 32'(expRd));
            checkOutput("addrB", 32'(addrB), 32'(expAddr));
            checkOutput("deB", 32'(deB), 32'(pipe[3].de));
            checkOutput("rgbB", 32'({rB, gB, bB}), 32'(applyMask(pipe[3].rgb, swAtEdge)));
        end
    end

    task automatic applyStimulus(input logic de, input int xx, input int yy);
        @(negedge clk);
        DE = de;
        x  = 10'(xx);
        y  = 10'(yy);
    endtask

    task automatic runLine(input int yy, input int len);
        for (int i = 0; i < len; i++) applyStimulus(1'b1, i, yy);
        applyStimulus(1'b0, len - 1, yy);
        applyStimulus(1'b0, len - 1, yy);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addrA"}, 32'(addrA), 32'd0);
        checkOutput({tag, "_rdA"}, 32'(rdA), 32'd0);
        checkOutput({tag, "_deA"}, 32'(deA), 32'd0);
        checkOutput({tag, "_rgbA"}, 32'({rA, gA, bA}), 32'd0);
        checkOutput({tag, "_addrB"}, 32'(addrB), 32'd0);
        checkOutput({tag, "_rdB"}, 32'(rdB), 32'd0);
        checkOutput({tag, "_deB"}, 32'(deB), 32'd0);
        checkOutput({tag, "_rgbB"}, 32'({rB, gB, bB}), 32'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 checkAllZero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Activity before any (0,0) must not read.
        runLine(7, 4);

        // Frame A: 2x, scale request to 1x arrives mid-frame.
        for (int yy = 0; yy < 480; yy++) begin
            if (yy == 100) scale_sel = 2'd0;
            if (yy == 5) begin
                for (int i = 0; i < 4; i++) applyStimulus(1'b1, i, 5);
                applyStimulus(1'b0, 3, 5);
                checkOutput("lit_2x_rd", 32'(rdA), 32'd1);
                checkOutput("lit_2x_addr641", 32'(addrA), 32'd641);
                applyStimulus(1'b0, 3, 5);
                checkOutput("lit_2x_deA", 32'(deA), 32'd1);
                checkOutput("lit_F81F_rgbA", 32'({rA, gA, bA}), 32'hF0F);
                applyStimulus(1'b0, 3, 5);
                applyStimulus(1'b0, 3, 5);
                checkOutput("lit_L4_deB", 32'(deB), 32'd1);
                checkOutput("lit_F81F_rgbB", 32'({rB, gB, bB}), 32'hF0F);
            end else if (yy == 101) begin
                for (int i = 0; i < 3; i++) applyStimulus(1'b1, i, 101);
                applyStimulus(1'b0, 2, 101);
                checkOutput("lit_midframe_stays_2x", 32'(addrA), 32'd16001);
                applyStimulus(1'b0, 2, 101);
            end else begin
                runLine(yy, 4);
            end
        end

        // Frame B: 1x now in effect.
        for (int i = 0; i < 322; i++) begin
            applyStimulus(1'b1, i, 0);
            if (i == 320) begin
                checkOutput("lit_1x_rd319", 32'(rdA), 32'd1);
                checkOutput("lit_1x_addr319", 32'(addrA), 32'd319);
            end
            if (i == 321) checkOutput("lit_1x_rd_x320", 32'(rdA), 32'd0);
        end
        applyStimulus(1'b0, 321, 0);
        checkOutput("lit_1x_de_x320", 32'(deA), 32'd1);
        checkOutput("lit_1x_black_x320", 32'({rA, gA, bA}), 32'd0);
        applyStimulus(1'b0, 321, 0);
        for (int yy = 1; yy < 240; yy++) runLine(yy, 4);
        applyStimulus(1'b1, 0, 240);
        applyStimulus(1'b0, 0, 240);
        checkOutput("lit_1x_rd_y240", 32'(rdA), 32'd0);
        applyStimulus(1'b0, 0, 240);
        for (int yy = 241; yy < 480; yy++) runLine(yy, 2);

        // Frame C: 4x, with channel switch changes along the way.
        scale_sel = 2'd2;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, i, 0);
            if (i >= 5) checkOutput("lit_4x_addr1", 32'(addrA), 32'd1);
        end
        applyStimulus(1'b0, 7, 0);
        checkOutput("lit_4x_addr1_x7", 32'(addrA), 32'd1);
        applyStimulus(1'b0, 7, 0);
        for (int yy = 1; yy < 479; yy++) begin
            if (yy == 200) sw_rgb = 3'b010;
            if (yy == 300) sw_rgb = 3'b111;
            runLine(yy, 4);
        end
        for (int i = 0; i < 640; i++) applyStimulus(1'b1, i, 479);
        applyStimulus(1'b0, 639, 479);
        checkOutput("lit_4x_rd_last", 32'(rdA), 32'd1);
        checkOutput("lit_4x_addr38239", 32'(addrA), 32'd38239);
        applyStimulus(1'b0, 639, 479);

        // Frame D: reserved scale code, reset mid-line.
        scale_sel = 2'd3;
        for (int yy = 0; yy < 150; yy++) runLine(yy, 4);
        for (int i = 0; i <= 200; i++) applyStimulus(1'b1, i, 150);
        #2 reset = 1'b1;
        #1 checkAllZero("async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int yy = 151; yy < 156; yy++) begin
            runLine(yy, 4);
            checkOutput("lit_post_reset_rd", 32'(rdA), 32'd0);
        end

        // Frame E: 1x after reset, reads resume at (0,0).
        scale_sel = 2'd0;
        runLine(0, 4);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i, 1);
        applyStimulus(1'b0, 3, 1);
        checkOutput("lit_resume_rd", 32'(rdA), 32'd1);
        checkOutput("lit_resume_addr323", 32'(addrA), 32'd323);
        applyStimulus(1'b0, 3, 1);
        for (int yy = 2; yy < 6; yy++) runLine(yy, 4);
        repeat (6) applyStimulus(1'b0, 0, 6);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
